// File: rtl/analyzer_pkg.sv
// -----------------------------------------------------------------------------
// analyzer_pkg
// Shared definitions for the logic-analyzer capture controller:
//   - state encoding of the capture FSM (registered, 3 bits)
//   - constants used to clamp the runtime pre/post configuration
// No ports (package).
// -----------------------------------------------------------------------------
package analyzer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_PRE_FILL  = 3'd2,
        S_WAIT_TRIG = 3'd3,
        S_POST      = 3'd4
    } state_t;

    // Shortest post-trigger window: the trigger sample on its own.
    localparam int POST_MIN = 1;

    // Sample RAM depth for a given address width; the largest legal
    // post-trigger window equals one full buffer.
    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/trigger_stage_seq.sv
// -----------------------------------------------------------------------------
// trigger_stage_seq
// N-stage sequential trigger. Holds the current stage index and evaluates only
// that stage's comparator hit; at most one advance per enabled sample. A hit
// on the last stage is reported as final_hit and the index holds there.
// Ports:
//   clock, reset_n  clock / async active-low reset
//   clear           return to stage 0 (start of a capture)
//   enable          a sample is being evaluated this cycle
//   stage_hit       per-stage comparator match
//   stage           current stage index
//   final_hit       last stage matched this cycle (the trigger)
// -----------------------------------------------------------------------------
module trigger_stage_seq #(
    parameter int STAGES = 2,
    parameter int STG_W  = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [STAGES-1:0] stage_hit,
    output logic [STG_W-1:0]  stage,
    output logic              final_hit
);

    localparam logic [STG_W-1:0] LAST  = STG_W'(STAGES - 1);
    localparam logic [STG_W-1:0] ONE_S = STG_W'(1);

    logic cur_hit;
    logic is_last;

    // Mux out the current stage's hit without a variable-width bit select.
    always_comb begin
        cur_hit = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (stage == STG_W'(i)) begin
                cur_hit = stage_hit[i];
            end
        end
    end

    assign is_last   = (stage == LAST);
    assign final_hit = enable && cur_hit && is_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage <= '0;
        end else if (clear) begin
            stage <= '0;
        end else if (enable && cur_hit && !is_last) begin
            stage <= stage + ONE_S;
        end
    end

endmodule

// File: rtl/analyzer_capture_ctrl.sv
// -----------------------------------------------------------------------------
// analyzer_capture_ctrl
// Capture controller for the logic analyzer. Arms on a start request
// (released start begins the capture), pre-fills the circular sample RAM,
// runs the sequential trigger, then writes the post-trigger window and
// pulses done. abort returns to idle from any active state and pulses aborted.
// Optional build macro ANALYZER_TRIG_TIMEOUT_EN adds a trigger timeout
// (parameter TMO_W, input timeout_limit, sticky output timed_out).
// Ports:
//   clock, reset_n        clock / async active-low reset
//   start, abort          host arm request (level) / cancel (level, priority)
//   sample_en             one strobe per sample
//   stage_hit             per-stage trigger comparator match
//   pre_count, post_count runtime window sizes, latched at arm
//   idle/running/triggered  state flags
//   stage                 current trigger stage
//   wr_en, wr_addr        sample RAM write port
//   trig_addr             address of the trigger sample
//   done, aborted         one-cycle completion pulses
// -----------------------------------------------------------------------------
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   S_IDLE      | waiting for start; results held for readback
//   S_ARM       | config latched, waiting for start to be released
//   S_PRE_FILL  | writing the minimum pre-trigger history, hits ignored
//   S_WAIT_TRIG | writing samples while the stage sequencer runs
//   S_POST      | writing the post-trigger window
// -----------------------------------------------------------------------------
module analyzer_capture_ctrl
    import analyzer_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int STAGES = 2,
    parameter int STG_W  = 3
`ifdef ANALYZER_TRIG_TIMEOUT_EN
    , parameter int TMO_W = 16
`endif
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              sample_en,
    input  logic [STAGES-1:0] stage_hit,
    input  logic [ADDR_W-1:0] pre_count,
    input  logic [ADDR_W:0]   post_count,
`ifdef ANALYZER_TRIG_TIMEOUT_EN
    input  logic [TMO_W-1:0]  timeout_limit,
    output logic              timed_out,
`endif
    output logic              idle,
    output logic              running,
    output logic              triggered,
    output logic [STG_W-1:0]  stage,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              done,
    output logic              aborted
);

    localparam logic [ADDR_W:0]   POST_MAX = (ADDR_W + 1)'(depth_of(ADDR_W));
    localparam logic [ADDR_W:0]   POST_LO  = (ADDR_W + 1)'(POST_MIN);
    localparam logic [ADDR_W:0]   ONE_P    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

    state_t state, state_nxt;

    logic [ADDR_W-1:0] pre_q, pre_cnt;
    logic [ADDR_W:0]   post_q, post_cnt, post_clamp;
    logic              arm_take, seq_clear, seq_en;
    logic              final_hit, trig_fire, trig_take;
    logic              pre_last, post_last;

    // pre_count already fits below the buffer depth; only post needs clamping.
    always_comb begin
        post_clamp = post_count;
        if (post_count == '0) begin
            post_clamp = POST_LO;
        end else if (post_count > POST_MAX) begin
            post_clamp = POST_MAX;
        end
    end

    assign arm_take  = (state == S_IDLE) && start && !abort;
    assign seq_clear = (state == S_ARM) && !start && !abort;
    assign seq_en    = (state == S_WAIT_TRIG) && sample_en && !abort;
    assign trig_take = (state == S_WAIT_TRIG) && trig_fire && !abort;

    // Leave pre-fill on the write that completes the window, so exactly
    // pre_q samples precede the first trigger-eligible sample. A zero window
    // still spends one cycle here.
    assign pre_last  = (pre_cnt == pre_q) || (wr_en && ((pre_cnt + ONE_A) == pre_q));
    assign post_last = (post_cnt == post_q);

    assign wr_en = sample_en && ((state == S_PRE_FILL) || (state == S_WAIT_TRIG) ||
                                 ((state == S_POST) && !post_last));

    assign idle      = (state == S_IDLE);
    assign running   = (state == S_PRE_FILL) || (state == S_WAIT_TRIG);
    assign triggered = (state == S_POST);
    assign done      = (state == S_POST) && post_last && !abort;
    assign aborted   = abort && (state != S_IDLE);

    trigger_stage_seq #(
        .STAGES (STAGES),
        .STG_W  (STG_W)
    ) u_seq (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (seq_clear),
        .enable    (seq_en),
        .stage_hit (stage_hit),
        .stage     (stage),
        .final_hit (final_hit)
    );

`ifdef ANALYZER_TRIG_TIMEOUT_EN
    localparam logic [TMO_W-1:0] ONE_T = TMO_W'(1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_fire;

    assign tmo_fire = (state == S_WAIT_TRIG) && sample_en && !abort &&
                      (timeout_limit != '0) && ((tmo_cnt + ONE_T) == timeout_limit);
    assign trig_fire = final_hit || tmo_fire;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt   <= '0;
            timed_out <= 1'b0;
        end else begin
            if (arm_take) begin
                timed_out <= 1'b0;
            end else if (tmo_fire) begin
                timed_out <= 1'b1;
            end
            if (seq_clear) begin
                tmo_cnt <= '0;
            end else if ((state == S_WAIT_TRIG) && sample_en) begin
                tmo_cnt <= tmo_cnt + ONE_T;
            end
        end
    end
`else
    assign trig_fire = final_hit;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start && !abort) state_nxt = S_ARM;
            S_ARM:       if (!start)          state_nxt = S_PRE_FILL;
            S_PRE_FILL:  if (pre_last)        state_nxt = S_WAIT_TRIG;
            S_WAIT_TRIG: if (trig_fire)       state_nxt = S_POST;
            S_POST:      if (post_last)       state_nxt = S_IDLE;
            default:                          state_nxt = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_q     <= '0;
            post_q    <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            wr_addr   <= '0;
            trig_addr <= '0;
        end else begin
            if (arm_take) begin
                pre_q  <= pre_count;
                post_q <= post_clamp;
            end
            if (seq_clear) begin
                wr_addr  <= '0;
                pre_cnt  <= '0;
                post_cnt <= '0;
            end else begin
                // Natural wrap of wr_addr gives the circular buffer.
                if (wr_en) begin
                    wr_addr <= wr_addr + ONE_A;
                end
                if ((state == S_PRE_FILL) && wr_en) begin
                    pre_cnt <= pre_cnt + ONE_A;
                end
                // The trigger sample is the first post-window sample.
                if (trig_take) begin
                    post_cnt  <= ONE_P;
                    trig_addr <= wr_addr;
                end else if ((state == S_POST) && wr_en) begin
                    post_cnt <= post_cnt + ONE_P;
                end
            end
        end
    end

endmodule

// File: tb/tb_analyzer_capture_ctrl.sv
`timescale 1ns/1ps
module tb_analyzer_capture_ctrl;

    localparam int AW = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // DUT a: single-stage trigger
    logic          a_start = 1'b0, a_abort = 1'b0, a_sen = 1'b0;
    logic [0:0]    a_hit   = '0;
    logic [AW-1:0] a_pre   = '0;
    logic [AW:0]   a_post  = '0;
    logic          a_idle, a_running, a_triggered, a_wr_en, a_done, a_aborted;
    logic [1:0]    a_stage;
    logic [AW-1:0] a_wr_addr, a_trig_addr;

    // DUT b: three-stage trigger
    logic          b_start = 1'b0, b_abort = 1'b0, b_sen = 1'b0;
    logic [2:0]    b_hit   = '0;
    logic [AW-1:0] b_pre   = '0;
    logic [AW:0]   b_post  = '0;
    logic          b_idle, b_running, b_triggered, b_wr_en, b_done, b_aborted;
    logic [1:0]    b_stage;
    logic [AW-1:0] b_wr_addr, b_trig_addr;

`ifdef ANALYZER_TRIG_TIMEOUT_EN
    logic [15:0] a_tmo = '0;
    logic [15:0] b_tmo = '0;
    logic        a_timed_out, b_timed_out;
`endif

    analyzer_capture_ctrl #(.ADDR_W(AW), .STAGES(1), .STG_W(2)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .start(a_start), .abort(a_abort),
        .sample_en(a_sen), .stage_hit(a_hit), .pre_count(a_pre), .post_count(a_post),
`ifdef ANALYZER_TRIG_TIMEOUT_EN
        .timeout_limit(a_tmo), .timed_out(a_timed_out),
`endif
        .idle(a_idle), .running(a_running), .triggered(a_triggered), .stage(a_stage),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .trig_addr(a_trig_addr),
        .done(a_done), .aborted(a_aborted)
    );

    analyzer_capture_ctrl #(.ADDR_W(AW), .STAGES(3), .STG_W(2)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .start(b_start), .abort(b_abort),
        .sample_en(b_sen), .stage_hit(b_hit), .pre_count(b_pre), .post_count(b_post),
`ifdef ANALYZER_TRIG_TIMEOUT_EN
        .timeout_limit(b_tmo), .timed_out(b_timed_out),
`endif
        .idle(b_idle), .running(b_running), .triggered(b_triggered), .stage(b_stage),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .trig_addr(b_trig_addr),
        .done(b_done), .aborted(b_aborted)
    );

    // Write monitor for DUT a, sampled mid-cycle.
    int wr_cnt = 0, post_wr_cnt = 0, wrap_cnt = 0, en_bad = 0, prev_addr = -1;
    always @(negedge clock) begin
        if (a_wr_en) begin
            wr_cnt++;
            if (a_triggered) post_wr_cnt++;
            if (!a_sen) en_bad++;
            if (prev_addr == 15 && a_wr_addr == 4'd0) wrap_cnt++;
            prev_addr = int'(a_wr_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic arm_a(input logic [AW-1:0] pre, input logic [AW:0] post);
        a_pre   = pre;
        a_post  = post;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        step();
    endtask

    // Call right after step(); returns with the done cycle settled.
    task automatic wait_done_a(input int budget, output int cyc);
        cyc = -1;
        for (int i = 0; i < budget; i++) begin
            settle();
            if (a_done) begin
                cyc = i;
                break;
            end
            step();
        end
        if (cyc < 0) chk("done_timeout", a_done, 1);
    endtask

    logic [2:0] hit_seq [5] = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b100};
    int         exp_stg [5] = '{0, 0, 0, 1, 2};

    initial begin
        int cyc, w0, p0, e0, r0;
        bit got_done;

        #12;
        chk("rst_idle", a_idle, 1);
        chk("rst_running", a_running, 0);
        chk("rst_triggered", a_triggered, 0);
        chk("rst_stage", a_stage, 0);
        chk("rst_wr_en", a_wr_en, 0);
        chk("rst_wr_addr", a_wr_addr, 0);
        chk("rst_trig_addr", a_trig_addr, 0);
        chk("rst_done", a_done, 0);
        chk("rst_aborted", a_aborted, 0);
        chk("rst_b_idle", b_idle, 1);
        reset_n = 1'b1;
        step();

        // abort in IDLE is ignored
        a_abort = 1'b1;
        settle();
        chk("idle_abort_pulse", a_aborted, 0);
        step();
        a_abort = 1'b0;
        settle();
        chk("idle_abort_state", a_idle, 1);

        // pre=3 post=4, trigger on 6th sample
        a_sen = 1'b1;
        a_hit = 1'b0;
        arm_a(4'd3, 5'd4);
        w0 = wr_cnt;
        repeat (5) step();
        a_hit = 1'b1;
        settle();
        chk("t1_running", a_running, 1);
        chk("t1_addr6", a_wr_addr, 5);
        step();
        a_hit = 1'b0;
        wait_done_a(20, cyc);
        chk("t1_done_cyc", cyc, 3);
        chk("t1_done_nowr", a_wr_en, 0);
        chk("t1_triggered", a_triggered, 1);
        chk("t1_trig_addr", a_trig_addr, 5);
        step();
        settle();
        chk("t1_idle", a_idle, 1);
        chk("t1_done_pulse", a_done, 0);
        chk("t1_wr_addr", a_wr_addr, 9);
        chk("t1_writes", wr_cnt - w0, 9);

        // hit held through PRE_FILL: no early trigger
        a_hit = 1'b1;
        arm_a(4'd3, 5'd2);
        w0 = wr_cnt;
        repeat (2) step();
        settle();
        chk("t2_pre_running", a_running, 1);
        chk("t2_pre_not_trig", a_triggered, 0);
        step();
        settle();
        chk("t2_wait_addr", a_wr_addr, 3);
        step();
        wait_done_a(20, cyc);
        chk("t2_done_cyc", cyc, 1);
        chk("t2_trig_addr", a_trig_addr, 3);
        step();
        settle();
        chk("t2_idle", a_idle, 1);
        chk("t2_wr_addr", a_wr_addr, 5);
        chk("t2_writes", wr_cnt - w0, 5);

        // abort on the completion cycle wins
        arm_a(4'd0, 5'd2);
        step();
        step();
        step();
        a_abort = 1'b1;
        settle();
        chk("t4_aborted", a_aborted, 1);
        chk("t4_no_done", a_done, 0);
        step();
        a_abort = 1'b0;
        settle();
        chk("t4_idle", a_idle, 1);
        chk("t4_abort_pulse_end", a_aborted, 0);
        chk("t4_trig_addr_hold", a_trig_addr, 1);
        chk("t4_wr_addr_hold", a_wr_addr, 3);

        // post=0 behaves as 1; start held at completion re-arms
        arm_a(4'd0, 5'd0);
        w0 = wr_cnt;
        step();
        step();
        wait_done_a(10, cyc);
        chk("t6_done_cyc", cyc, 0);
        a_start = 1'b1;
        step();
        settle();
        chk("t6_idle", a_idle, 1);
        chk("t6_writes", wr_cnt - w0, 2);
        step();
        settle();
        chk("t6_rearm_not_idle", a_idle, 0);
        chk("t6_rearm_not_run", a_running, 0);
        a_start = 1'b0;
        step();
        a_abort = 1'b1;
        settle();
        chk("t6_prefill", a_running, 1);
        chk("t6_addr_cleared", a_wr_addr, 0);
        chk("t6_abort_prefill", a_aborted, 1);
        step();
        a_abort = 1'b0;
        settle();
        chk("t6_abort_idle", a_idle, 1);

        // post=20 clamps to 16
        arm_a(4'd0, 5'd20);
        w0 = wr_cnt;
        step();
        step();
        wait_done_a(40, cyc);
        chk("t7_done_cyc", cyc, 15);
        step();
        settle();
        chk("t7_writes", wr_cnt - w0, 17);
        chk("t7_wr_addr", a_wr_addr, 1);

        // pre=14 post=16 with a strobe every 3rd cycle, buffer wraps
        a_sen = 1'b0;
        arm_a(4'd14, 5'd16);
        w0 = wr_cnt; p0 = post_wr_cnt; e0 = en_bad; r0 = wrap_cnt;
        got_done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            a_sen = (i % 3 == 2);
            settle();
            if (a_done) begin
                got_done = 1'b1;
                break;
            end
            step();
        end
        chk("t5_done_seen", got_done, 1);
        chk("t5_writes", wr_cnt - w0, 30);
        chk("t5_post_state_writes", post_wr_cnt - p0, 15);
        chk("t5_wrap", wrap_cnt - r0, 1);
        chk("t5_wr_on_strobe", en_bad - e0, 0);
        chk("t5_trig_addr", a_trig_addr, 14);
        chk("t5_wr_addr", a_wr_addr, 14);
        a_sen = 1'b1;
        step();

        // three-stage sequence with out-of-order hits
        b_sen   = 1'b1;
        b_pre   = 4'd0;
        b_post  = 5'd1;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            b_hit = hit_seq[k];
            settle();
            chk($sformatf("t3_stage_%0d", k), b_stage, exp_stg[k]);
            chk($sformatf("t3_wait_%0d", k), b_triggered, 0);
            step();
        end
        b_hit = '0;
        settle();
        chk("t3_triggered", b_triggered, 1);
        chk("t3_trig_addr", b_trig_addr, 5);
        chk("t3_done", b_done, 1);
        step();
        settle();
        chk("t3_idle", b_idle, 1);

`ifdef ANALYZER_TRIG_TIMEOUT_EN
        // forced trigger on the 5th WAIT_TRIG sample
        a_hit = 1'b0;
        a_tmo = 16'd5;
        arm_a(4'd0, 5'd2);
        step();
        repeat (4) step();
        settle();
        chk("tmo_wait", a_triggered, 0);
        chk("tmo_not_yet", a_timed_out, 0);
        chk("tmo_addr", a_wr_addr, 5);
        step();
        wait_done_a(10, cyc);
        chk("tmo_done_cyc", cyc, 1);
        chk("tmo_trig_addr", a_trig_addr, 5);
        chk("tmo_flag", a_timed_out, 1);
        step();
        settle();
        chk("tmo_idle", a_idle, 1);
        chk("tmo_sticky", a_timed_out, 1);
        a_start = 1'b1;
        step();
        settle();
        chk("tmo_clear_on_arm", a_timed_out, 0);
        a_start = 1'b0;
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        a_tmo   = 16'd0;
        settle();
        chk("tmo_abort_idle", a_idle, 1);
`endif

        // async reset in the middle of POST
        a_hit = 1'b1;
        arm_a(4'd0, 5'd8);
        step();
        step();
        settle();
        chk("rstm_in_post", a_triggered, 1);
        reset_n = 1'b0;
        #1;
        chk("rstm_idle", a_idle, 1);
        chk("rstm_running", a_running, 0);
        chk("rstm_triggered", a_triggered, 0);
        chk("rstm_stage", a_stage, 0);
        chk("rstm_wr_en", a_wr_en, 0);
        chk("rstm_wr_addr", a_wr_addr, 0);
        chk("rstm_trig_addr", a_trig_addr, 0);
        chk("rstm_done", a_done, 0);
        chk("rstm_aborted", a_aborted, 0);
        step();
        reset_n = 1'b1;
        settle();
        chk("rstm_after", a_idle, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1);
    end

endmodule
